// File: rtl/prog_delay_line_if.sv
// Sample/control bundle for the programmable delay line: producer side is master,
// the delay line itself is slave.
interface prog_delay_line_if #(
    parameter int WIDTH     = 8,
    parameter int MAX_DELAY = 16,
    parameter int DW        = 5
);
    logic                       clk_ena;
    logic [DW-1:0]              delay;
    logic [WIDTH-1:0]           din;
    logic                       din_vld;
    logic                       load;
    logic [WIDTH*MAX_DELAY-1:0] dfload;
    logic [WIDTH-1:0]           dout;
    logic                       dout_vld;
    logic [WIDTH*MAX_DELAY-1:0] doutbig;
    logic                       busy;

    modport master (
        output clk_ena, delay, din, din_vld, load, dfload,
        input  dout, dout_vld, doutbig, busy
    );

    modport slave (
        input  clk_ena, delay, din, din_vld, load, dfload,
        output dout, dout_vld, doutbig, busy
    );
endinterface

// File: rtl/prog_delay_line.sv
// Programmable delay line with clamped runtime delay, per-stage valid, refill FSM
// and whole-line parallel load/readout.
module prog_delay_line_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             ld_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] shift_d_i,
    input  logic             shift_vld_i,
    input  logic [WIDTH-1:0] ld_d_i,
    output logic [WIDTH-1:0] data_o,
    output logic             vld_o
);
    logic [WIDTH-1:0] data_q;
    logic             vld_q;

    // Load beats a delay-change clear: loaded stages are always valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else if (en_i) begin
            if (ld_i) begin
                data_q <= ld_d_i;
                vld_q  <= 1'b1;
            end else begin
                data_q <= shift_d_i;
                vld_q  <= shift_vld_i & ~clr_i;
            end
        end
    end

    assign data_o = data_q;
    assign vld_o  = vld_q;
endmodule

module prog_delay_line #(
    parameter int WIDTH     = 8,
    parameter int MAX_DELAY = 16,
    parameter int DW        = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    prog_delay_line_if.slave     bus
);
    typedef enum logic {RUN, FILL} state_t;

    state_t                              state_q;
    logic [DW-1:0]                       cur_delay_q;
    logic [DW-1:0]                       cnt_q;
    logic [DW-1:0]                       delay_d;
    logic                                delay_chg;
    logic [MAX_DELAY-1:0][WIDTH-1:0]     stage_q;
    logic [MAX_DELAY-1:0][WIDTH-1:0]     ld_data;
    logic [MAX_DELAY-1:0]                vld_q;
    logic [WIDTH-1:0]                    tap_data;
    logic                                tap_vld;

    assign delay_d   = (bus.delay > DW'(MAX_DELAY)) ? DW'(MAX_DELAY) : bus.delay;
    assign delay_chg = (delay_d != cur_delay_q);
    assign ld_data   = bus.dfload;

    for (genvar k = 0; k < MAX_DELAY; k++) begin : g_stage
        logic [WIDTH-1:0] shift_d;
        logic             shift_vld;
        if (k == 0) begin : g_head
            assign shift_d   = bus.din;
            assign shift_vld = bus.din_vld;
        end else begin : g_body
            assign shift_d   = stage_q[k-1];
            assign shift_vld = vld_q[k-1];
        end

        prog_delay_line_stage #(.WIDTH(WIDTH)) u_stage (
            .clk         (clk),
            .rst         (rst),
            .en_i        (bus.clk_ena),
            .ld_i        (bus.load),
            .clr_i       (delay_chg),
            .shift_d_i   (shift_d),
            .shift_vld_i (shift_vld),
            .ld_d_i      (ld_data[k]),
            .data_o      (stage_q[k]),
            .vld_o       (vld_q[k])
        );
    end

    // Fill tracker: counts enabled edges until the new tap holds freshly shifted data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            cur_delay_q <= '0;
            cnt_q       <= '0;
        end else if (bus.clk_ena) begin
            if (delay_chg)
                cur_delay_q <= delay_d;
            if (bus.load) begin
                state_q <= RUN;
                cnt_q   <= '0;
            end else if (delay_chg) begin
                cnt_q   <= '0;
                state_q <= (delay_d != '0) ? FILL : RUN;
            end else if (state_q == FILL) begin
                if (cnt_q == cur_delay_q - DW'(1)) begin
                    state_q <= RUN;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + DW'(1);
                end
            end
        end
    end

    // One-hot compare mux avoids indexing the stage array with an over-wide select.
    always_comb begin
        tap_data = '0;
        tap_vld  = 1'b0;
        for (int k = 0; k < MAX_DELAY; k++) begin
            if (cur_delay_q == DW'(k + 1)) begin
                tap_data = stage_q[k];
                tap_vld  = vld_q[k];
            end
        end
    end

    assign bus.dout     = (cur_delay_q == '0) ? bus.din     : tap_data;
    assign bus.dout_vld = (cur_delay_q == '0) ? bus.din_vld : tap_vld;
    assign bus.doutbig  = stage_q;
    assign bus.busy     = (state_q == FILL);
endmodule

// File: tb/tb_prog_delay_line.sv
// Directed bench for prog_delay_line: bypass, latency, clock enable, clamp,
// delay change, parallel load and reset during fill.
module tb_prog_delay_line;
    localparam int W  = 8;
    localparam int MD = 16;
    localparam int DW = 5;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    prog_delay_line_if #(.WIDTH(W), .MAX_DELAY(MD), .DW(DW)) bus ();

    prog_delay_line #(.WIDTH(W), .MAX_DELAY(MD), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus.clk_ena = 1'b0;
        bus.load    = 1'b0;
        bus.delay   = '0;
        bus.din     = '0;
        bus.din_vld = 1'b0;
        bus.dfload  = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        #1;
        tests_run++;
        if (bus.doutbig !== '0) begin
            tests_failed++;
            $display("FAIL reset_doutbig: got %h want 0", bus.doutbig);
        end
        tests_run++;
        if (bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_busy: got %b want 0", bus.busy);
        end
        bus.din     = 8'h5A;
        bus.din_vld = 1'b1;
        #1;
        tests_run++;
        if ({bus.dout_vld, bus.dout} !== {1'b1, 8'h5A}) begin
            tests_failed++;
            $display("FAIL bypass: got vld=%b dout=%h want vld=1 dout=5a", bus.dout_vld, bus.dout);
        end
    endtask

    task automatic test_delay3();
        logic [W-1:0] exp_d;
        logic         exp_v;
        do_reset();
        bus.clk_ena = 1'b1;
        bus.delay   = 5'd3;
        tick();
        for (int c = 1; c <= 6; c++) begin
            bus.din     = W'(c);
            bus.din_vld = 1'b1;
            #1;
            exp_v = (c >= 4);
            exp_d = (c >= 4) ? W'(c - 3) : '0;
            tests_run++;
            if (bus.busy !== (c <= 3)) begin
                tests_failed++;
                $display("FAIL delay3_busy c=%0d: got %b want %b", c, bus.busy, (c <= 3));
            end
            tests_run++;
            if ({bus.dout_vld, bus.dout} !== {exp_v, exp_d}) begin
                tests_failed++;
                $display("FAIL delay3_dout c=%0d: got vld=%b dout=%h want vld=%b dout=%h",
                         c, bus.dout_vld, bus.dout, exp_v, exp_d);
            end
            tick();
        end
    endtask

    task automatic test_clk_ena();
        logic [W-1:0] exp_d;
        logic         exp_v;
        do_reset();
        bus.clk_ena = 1'b1;
        bus.delay   = 5'd3;
        tick();
        for (int n = 1; n <= 6; n++) begin
            bus.clk_ena = 1'b1;
            bus.din     = W'(n);
            bus.din_vld = 1'b1;
            #1;
            exp_v = (n >= 4);
            exp_d = (n >= 4) ? W'(n - 3) : '0;
            tests_run++;
            if ({bus.busy, bus.dout_vld, bus.dout} !== {(n <= 3), exp_v, exp_d}) begin
                tests_failed++;
                $display("FAIL ena_on n=%0d: got busy=%b vld=%b dout=%h want busy=%b vld=%b dout=%h",
                         n, bus.busy, bus.dout_vld, bus.dout, (n <= 3), exp_v, exp_d);
            end
            tick();
            // disabled cycle: garbage input must not shift in
            bus.clk_ena = 1'b0;
            bus.din     = 8'hEE;
            bus.din_vld = 1'b1;
            #1;
            exp_v = (n >= 3);
            exp_d = (n >= 3) ? W'(n - 2) : '0;
            tests_run++;
            if ({bus.busy, bus.dout_vld, bus.dout} !== {(n <= 2), exp_v, exp_d}) begin
                tests_failed++;
                $display("FAIL ena_off n=%0d: got busy=%b vld=%b dout=%h want busy=%b vld=%b dout=%h",
                         n, bus.busy, bus.dout_vld, bus.dout, (n <= 2), exp_v, exp_d);
            end
            tick();
        end
    endtask

    task automatic test_clamp_and_change();
        do_reset();
        bus.clk_ena = 1'b1;
        bus.delay   = 5'd20;
        tick();
        for (int e = 1; e <= 18; e++) begin
            bus.din     = W'(e);
            bus.din_vld = 1'b1;
            #1;
            tests_run++;
            if (bus.busy !== (e <= 16)) begin
                tests_failed++;
                $display("FAIL clamp_busy e=%0d: got %b want %b", e, bus.busy, (e <= 16));
            end
            if (e >= 17) begin
                tests_run++;
                if ({bus.dout_vld, bus.dout} !== {1'b1, W'(e - 16)}) begin
                    tests_failed++;
                    $display("FAIL clamp_dout e=%0d: got vld=%b dout=%h want vld=1 dout=%h",
                             e, bus.dout_vld, bus.dout, W'(e - 16));
                end
            end
            tick();
        end
        bus.delay = 5'd5;
        for (int e = 19; e <= 26; e++) begin
            bus.din     = W'(e);
            bus.din_vld = 1'b1;
            #1;
            if (e >= 20) begin
                tests_run++;
                if ({bus.busy, bus.dout_vld} !== {(e <= 24), (e >= 25)}) begin
                    tests_failed++;
                    $display("FAIL chg5_flags e=%0d: got busy=%b vld=%b want busy=%b vld=%b",
                             e, bus.busy, bus.dout_vld, (e <= 24), (e >= 25));
                end
            end
            if (e >= 25) begin
                tests_run++;
                if (bus.dout !== W'(e - 5)) begin
                    tests_failed++;
                    $display("FAIL chg5_dout e=%0d: got %h want %h", e, bus.dout, W'(e - 5));
                end
            end
            tick();
        end
    endtask

    task automatic test_load();
        logic [W*MD-1:0] big;
        do_reset();
        for (int k = 0; k < MD; k++) big[k*W +: W] = W'(8'h10 + k);
        bus.clk_ena = 1'b1;
        bus.delay   = 5'd4;
        bus.load    = 1'b1;
        bus.dfload  = big;
        bus.din     = 8'h77;
        bus.din_vld = 1'b1;
        tick();
        bus.load    = 1'b0;
        bus.clk_ena = 1'b0;
        #1;
        tests_run++;
        if (bus.doutbig !== big) begin
            tests_failed++;
            $display("FAIL load_big: got %h want %h", bus.doutbig, big);
        end
        tests_run++;
        if ({bus.busy, bus.dout_vld, bus.dout} !== {1'b0, 1'b1, 8'h13}) begin
            tests_failed++;
            $display("FAIL load_tap: got busy=%b vld=%b dout=%h want busy=0 vld=1 dout=13",
                     bus.busy, bus.dout_vld, bus.dout);
        end
        // load during FILL ends the fill
        bus.clk_ena = 1'b1;
        bus.delay   = 5'd8;
        bus.din     = 8'hA0;
        tick();
        tick();
        #1;
        tests_run++;
        if ({bus.busy, bus.dout_vld} !== 2'b10) begin
            tests_failed++;
            $display("FAIL fill_before_load: got busy=%b vld=%b want busy=1 vld=0", bus.busy, bus.dout_vld);
        end
        for (int k = 0; k < MD; k++) big[k*W +: W] = W'(8'h40 + k);
        bus.dfload = big;
        bus.load   = 1'b1;
        tick();
        bus.load    = 1'b0;
        bus.clk_ena = 1'b0;
        #1;
        tests_run++;
        if ({bus.busy, bus.dout_vld, bus.dout} !== {1'b0, 1'b1, 8'h47}) begin
            tests_failed++;
            $display("FAIL load_in_fill: got busy=%b vld=%b dout=%h want busy=0 vld=1 dout=47",
                     bus.busy, bus.dout_vld, bus.dout);
        end
        tests_run++;
        if (bus.doutbig !== big) begin
            tests_failed++;
            $display("FAIL load_in_fill_big: got %h want %h", bus.doutbig, big);
        end
    endtask

    task automatic test_rst_in_fill();
        do_reset();
        bus.clk_ena = 1'b1;
        bus.delay   = 5'd8;
        bus.din     = 8'h33;
        bus.din_vld = 1'b1;
        tick();
        tick();
        #1;
        tests_run++;
        if (bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_pre_busy: got %b want 1", bus.busy);
        end
        rst         = 1'b1;
        bus.clk_ena = 1'b0;
        tick();
        rst         = 1'b0;
        bus.din     = 8'h5C;
        bus.din_vld = 1'b1;
        #1;
        tests_run++;
        if ({bus.busy, bus.doutbig} !== {1'b0, {(W*MD){1'b0}}}) begin
            tests_failed++;
            $display("FAIL rst_fill_state: got busy=%b big=%h want busy=0 big=0", bus.busy, bus.doutbig);
        end
        tests_run++;
        if ({bus.dout_vld, bus.dout} !== {1'b1, 8'h5C}) begin
            tests_failed++;
            $display("FAIL rst_fill_bypass: got vld=%b dout=%h want vld=1 dout=5c", bus.dout_vld, bus.dout);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        bus.clk_ena  = 1'b0;
        bus.load     = 1'b0;
        bus.delay    = '0;
        bus.din      = '0;
        bus.din_vld  = 1'b0;
        bus.dfload   = '0;
        test_reset();
        test_delay3();
        test_clk_ena();
        test_clamp_and_change();
        test_load();
        test_rst_in_fill();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/prog_delay_line.md
# prog_delay_line

Multi-bit programmable delay line: the next-generation shift register of the gain-control datapath. It has a runtime-selectable delay of 0..MAX_DELAY clock-enabled cycles and a bypass at delay 0. Per-stage valid tracking, a fill state machine after delay changes, and whole-line parallel load/readout are included. It sits between sample producers and the gain-control arithmetic, where it aligns data paths of unequal latency.

## Interface
Parameters:
- WIDTH, 8, bits per sample
- MAX_DELAY, 16, number of storage stages, ≥1
- DW, 5, width of delay select, ≥ clog2(MAX_DELAY+1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- clk_ena  in  1  clock enable; no state changes when low (except rst)
- delay  in  DW  requested delay in enabled cycles; values > MAX_DELAY clamp to MAX_DELAY
- din  in  WIDTH  sample input
- din_vld  in  1  sample input valid
- load  in  1  parallel load of all stages (qualified by clk_ena)
- dfload  in  WIDTH*MAX_DELAY  load data; stage k ← dfload[(k+1)*WIDTH-1 : k*WIDTH]
- dout  out  WIDTH  delayed sample
- dout_vld  out  1  delayed sample valid
- doutbig  out  WIDTH*MAX_DELAY  all stages concatenated, stage 0 in LSBs
- busy  out  1  high while refilling after a delay change

## Operation
- Storage: stage[0..MAX_DELAY-1] (WIDTH bits each) plus vld[0..MAX_DELAY-1].
- cur_delay (DW bits) is the registered, clamped copy of delay; it drives the output tap.
- Shift (clk_ena=1, load=0): stage[0]←din, vld[0]←din_vld, stage[k]←stage[k-1], vld[k]←vld[k-1].
- Load (clk_ena=1, load=1): stage[k]←dfload slice k, all vld←1. Load has priority over shift, and din is discarded that cycle.
- Output tap:
  - cur_delay=0: dout=din, dout_vld=din_vld (combinational bypass).
  - Otherwise: dout=stage[cur_delay-1], dout_vld=vld[cur_delay-1].
- Delay change: on an enabled edge with clamp(delay)≠cur_delay:
  - cur_delay←clamp(delay).
  - All vld bits clear. This overrides the shifted-in vld[0]; stage data is kept.
  - fill counter←0.
  - state→FILL if the new delay is >0, else RUN.
- FSM states: RUN, FILL.
  - FILL: each enabled edge increments cnt. When cnt = cur_delay-1 on an enabled edge, go to RUN.
  - A new delay change in FILL restarts the fill. Load in FILL goes to RUN.
  - busy = (state==FILL).
- Delay change and load on the same edge: the new cur_delay is applied, stages are loaded, all vld←1, state→RUN.
- Stage data, vld bits and doutbig are unaffected when clk_ena=0.

## Timing
- Reset: all stages 0, all vld 0, cur_delay 0, cnt 0, state RUN.
  - After reset: doutbig=0, busy=0; dout/dout_vld follow din/din_vld (bypass).
- Latency: with constant cur_delay=D>0, dout equals the din presented at the D-th previous enabled edge. Disabled cycles do not count.
- delay is sampled only on enabled edges. The new tap is visible in the cycle after that edge.
- busy rises the cycle after the changing edge. It stays high for exactly D enabled edges, falling after the D-th.
- dout_vld goes high no earlier than the first cycle after busy falls, and only if valid input was shifted in during fill.
- rst mid-FILL or mid-load returns all state to reset values on that edge, regardless of clk_ena.
- All outputs are registered except the bypass path at cur_delay=0 and the tap mux select.

## Test plan
- Reset then delay=0: drive din=0x5A, din_vld=1 → dout=0x5A, dout_vld=1 in the same cycle; busy=0.
- delay=3, feed 1,2,3,4… valid every cycle:
  - busy high for 3 cycles after the change, then low.
  - dout=1 with dout_vld=1 exactly 3 enabled edges after 1 is sampled.
- Same stream as above with clk_ena toggling 1,0,1,0: the delay counts only enabled edges, so dout=1 appears after the 3rd enabled edge; nothing shifts on disabled cycles.
- MAX_DELAY=16, delay=20: cur_delay clamps to 16, giving 16-cycle latency. Changing delay to 5 mid-stream clears dout_vld and gives 5 busy cycles.
- load=1 with dfload stages = 0x10..0x1F, delay=4:
  - Next cycle: doutbig matches dfload, dout=0x13, dout_vld=1, busy=0.
  - Load asserted in FILL also ends FILL.
- rst asserted during FILL with delay=8: next cycle busy=0, doutbig=0, cur_delay=0 (bypass active).
